// File: rtl/rv_avm_master_bridge.sv
// rv_avm_master_bridge: pipelined command-to-Avalon-MM master with outstanding-read tracking,
// a byte-enable control register and edge-latched interrupts.
module rv_avm_master_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BE_ADDR = 32'hAFFFFFF0,
    parameter bit BE_STICKY = 1'b1,
    parameter int MAX_OUTSTANDING = 4,
    parameter int IRQ_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_wr,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic                    write,
    output logic                    read,
    output logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    waitrequest,
    input  logic [DATA_WIDTH-1:0]   readdata,
    input  logic                    readdatavalid,
    input  logic [IRQ_WIDTH-1:0]    irq,
    input  logic [IRQ_WIDTH-1:0]    irq_clr,
    output logic [IRQ_WIDTH-1:0]    irq_pending,
    output logic                    rsp_err
);
    localparam int BW = DATA_WIDTH / 8;
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    typedef enum logic {IDLE, BUS} state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic [BW-1:0]        be_reg;
    logic [IRQ_WIDTH-1:0] irq_hist;
    logic                 accept;
    logic                 inc;
    logic                 dec;

    assign cmd_ready = (state == IDLE) && (cnt < MAX_CNT);
    assign accept    = cmd_valid && cmd_ready;
    assign inc       = (state == BUS) && !waitrequest && read;
    // Returns with nothing outstanding are stray (e.g. from before a reset) and only flag rsp_err
    assign dec       = readdatavalid && (cnt != 4'd0);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            address     <= '0;
            writedata   <= '0;
            write       <= 1'b0;
            read        <= 1'b0;
            byteenable  <= '1;
            be_reg      <= '1;
            cnt         <= 4'd0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            irq_hist    <= '0;
            irq_pending <= '0;
        end else begin
            if (state == IDLE) begin
                if (accept) begin
                    if (cmd_wr && cmd_addr == BE_ADDR) begin
                        be_reg <= cmd_wdata[BW-1:0];
                    end else begin
                        address    <= cmd_addr;
                        writedata  <= cmd_wdata;
                        write      <= cmd_wr;
                        read       <= !cmd_wr;
                        byteenable <= cmd_wr ? be_reg : '1;
                        state      <= BUS;
                    end
                end
            end else if (!waitrequest) begin
                write <= 1'b0;
                read  <= 1'b0;
                state <= IDLE;
                if (write && !BE_STICKY)
                    be_reg <= '1;
            end
            cnt       <= cnt + 4'(inc) - 4'(dec);
            rsp_valid <= dec;
            if (dec)
                rsp_rdata <= readdata;
            if (readdatavalid && cnt == 4'd0)
                rsp_err <= 1'b1;
            irq_hist    <= irq;
            irq_pending <= (irq_pending & ~irq_clr) | (irq & ~irq_hist);
        end
    end
endmodule

// File: tb/tb_rv_avm_master_bridge.sv
// tb_rv_avm_master_bridge: table-driven and hand-sequenced checks of the bridge, sticky and
// one-shot byte-enable variants side by side, read data scored against an issue-order queue.
module tb_rv_avm_master_bridge;
    localparam logic [31:0] BE = 32'hAFFFFFF0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          w;
        logic [3:0]  be0;
        logic [3:0]  be1;
    } vec_t;

    logic        clk = 1'b0;
    logic        nreset;
    logic        cmd_valid, cmd_wr, waitrequest, readdatavalid;
    logic [31:0] cmd_addr, cmd_wdata, readdata;
    logic [2:0]  irq, irq_clr;
    logic        cmd_ready, rsp_valid, write, read, rsp_err;
    logic [31:0] rsp_rdata, address, writedata;
    logic [3:0]  byteenable;
    logic [2:0]  irq_pending;
    logic        cmd_ready_n, rsp_valid_n, write_n, read_n, rsp_err_n;
    logic [31:0] rsp_rdata_n, address_n, writedata_n;
    logic [3:0]  byteenable_n;
    logic [2:0]  irq_pending_n;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_rsp = 0;
    int          base;
    logic [31:0] sb[$];
    logic [31:0] pend[$];
    logic [31:0] e;
    vec_t        tv[8];

    always #5 clk = ~clk;

    rv_avm_master_bridge #(.BE_STICKY(1'b1)) dut (
        .clk(clk), .nreset(nreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .address(address),
        .write(write), .read(read), .writedata(writedata), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
        .irq(irq), .irq_clr(irq_clr), .irq_pending(irq_pending), .rsp_err(rsp_err)
    );

    rv_avm_master_bridge #(.BE_STICKY(1'b0)) dut_n (
        .clk(clk), .nreset(nreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_n),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_n), .rsp_rdata(rsp_rdata_n), .address(address_n),
        .write(write_n), .read(read_n), .writedata(writedata_n), .byteenable(byteenable_n),
        .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
        .irq(irq), .irq_clr(irq_clr), .irq_pending(irq_pending_n), .rsp_err(rsp_err_n)
    );

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic vec_t rv(input logic [31:0] a);
        return '{1'b0, a, 32'h0, 0, 4'hF, 4'hF};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input vec_t v);
        int t;
        t = 0;
        cmd_valid = 1'b1;
        cmd_wr    = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        while (!cmd_ready && t < 40) begin
            cycle();
            t++;
        end
        chk("accept_ready", {cmd_ready, cmd_ready_n}, 2'b11);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        cycle();
        cmd_valid = 1'b0;
        if (v.wr && v.addr == BE) begin
            chk("be_no_bus", {write, read, write_n, read_n}, 4'b0);
            cycle();
            chk("be_no_bus2", {write, read, write_n, read_n}, 4'b0);
            return;
        end
        if (!v.wr) begin
            sb.push_back(rd_val(v.addr));
            pend.push_back(v.addr);
        end
        for (int i = 0; i <= v.w; i++) begin
            waitrequest = (i < v.w);
            chk("bus_ctl", {write, read, write_n, read_n}, {v.wr, !v.wr, v.wr, !v.wr});
            chk("bus_addr", {address, address_n}, {v.addr, v.addr});
            chk("bus_be", byteenable, v.be0);
            chk("bus_be_n", byteenable_n, v.be1);
            if (v.wr)
                chk("bus_wdata", {writedata, writedata_n}, {v.wdata, v.wdata});
            cycle();
        end
        waitrequest = 1'b0;
        chk("bus_end", {write, read, write_n, read_n}, 4'b0);
    endtask

    task automatic ret();
        readdatavalid = 1'b1;
        readdata = rd_val(pend.pop_front());
        cycle();
        readdatavalid = 1'b0;
        chk("rsp_pulse", {rsp_valid, rsp_valid_n}, 2'b11);
    endtask

    always @(negedge clk) begin
        if (rsp_valid || rsp_valid_n) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e);
                chk("rsp_rdata_n", {rsp_valid_n, rsp_rdata_n}, {1'b1, e});
                n_rsp++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tv[0] = '{1'b1, BE,           32'h5,      0, 4'hF, 4'hF};
        tv[1] = '{1'b1, 32'h100,      32'h1234,   3, 4'h5, 4'h5};
        tv[2] = '{1'b1, 32'h104,      32'hBEEF,   0, 4'h5, 4'hF};
        tv[3] = '{1'b0, 32'h200,      32'h0,      2, 4'hF, 4'hF};
        tv[4] = '{1'b1, BE,           32'hA,      0, 4'hF, 4'hF};
        tv[5] = '{1'b1, 32'h108,      32'hCAFE,   1, 4'hA, 4'hA};
        tv[6] = '{1'b0, 32'h204,      32'h0,      0, 4'hF, 4'hF};
        tv[7] = '{1'b1, 32'h10C,      32'h55AA,   0, 4'hA, 4'hF};
        nreset = 1'b0;
        {cmd_valid, cmd_wr, waitrequest, readdatavalid} = 4'b0;
        cmd_addr = '0; cmd_wdata = '0; readdata = '0; irq = '0; irq_clr = '0;
        cycle();
        cycle();
        chk("rst_ctl", {write, read, write_n, read_n}, 4'b0);
        chk("rst_addr", {address, writedata}, 64'h0);
        chk("rst_be", {byteenable, byteenable_n}, 8'hFF);
        chk("rst_rsp", {rsp_valid, rsp_rdata, rsp_err}, 34'h0);
        chk("rst_irq", {irq_pending, irq_pending_n}, 6'h0);
        chk("rst_ready", {cmd_ready, cmd_ready_n}, 2'b11);
        nreset = 1'b1;
        cycle();
        // Table: BE register, waitrequest stretch, sticky vs one-shot
        for (int i = 0; i < 8; i++)
            do_cmd(tv[i]);
        ret();
        ret();
        cycle();
        chk("sb_drain1", sb.size(), 0);
        // Outstanding limit with delayed returns
        base = n_rsp;
        for (int k = 0; k < 4; k++)
            do_cmd(rv(32'h300 + 32'(4 * k)));
        chk("full_ready", {cmd_ready, cmd_ready_n}, 2'b00);
        cycle();
        chk("full_ready2", {cmd_ready, cmd_ready_n}, 2'b00);
        ret();
        chk("ready_restored", {cmd_ready, cmd_ready_n}, 2'b11);
        do_cmd(rv(32'h310));
        chk("full_again", {cmd_ready, cmd_ready_n}, 2'b00);
        for (int k = 0; k < 4; k++)
            ret();
        cycle();
        chk("rsp_count5", n_rsp - base, 5);
        chk("sb_drain2", sb.size(), 0);
        // Return coincident with a read completion leaves the count unchanged
        for (int k = 0; k < 3; k++)
            do_cmd(rv(32'h400 + 32'(4 * k)));
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h40C;
        chk("co_ready", {cmd_ready, cmd_ready_n}, 2'b11);
        cycle();
        cmd_valid = 1'b0;
        chk("co_read", {read, read_n}, 2'b11);
        readdatavalid = 1'b1;
        readdata = rd_val(pend.pop_front());
        pend.push_back(32'h40C);
        sb.push_back(rd_val(32'h40C));
        cycle();
        readdatavalid = 1'b0;
        chk("co_pulse", {rsp_valid, read}, 2'b10);
        chk("co_cnt_ready", {cmd_ready, cmd_ready_n}, 2'b11);
        do_cmd(rv(32'h410));
        chk("co_full", {cmd_ready, cmd_ready_n}, 2'b00);
        for (int k = 0; k < 4; k++)
            ret();
        chk("co_ready_end", {cmd_ready, cmd_ready_n}, 2'b11);
        cycle();
        chk("sb_drain3", sb.size(), 0);
        // Stray return with nothing outstanding
        chk("err_before", {rsp_err, rsp_err_n}, 2'b00);
        readdatavalid = 1'b1;
        readdata = 32'hDEADBEEF;
        cycle();
        readdatavalid = 1'b0;
        chk("stray_no_rsp", {rsp_valid, rsp_valid_n}, 2'b00);
        chk("stray_err", {rsp_err, rsp_err_n}, 2'b11);
        chk("stray_no_underflow", {cmd_ready, cmd_ready_n}, 2'b11);
        // Interrupts
        irq = 3'b010; irq_clr = 3'b010;
        cycle();
        chk("irq_set_wins", {irq_pending, irq_pending_n}, 6'b010010);
        cycle();
        chk("irq_cleared", {irq_pending, irq_pending_n}, 6'b0);
        irq_clr = 3'b000;
        cycle();
        cycle();
        chk("irq_held_high", {irq_pending, irq_pending_n}, 6'b0);
        irq = 3'b111;
        cycle();
        chk("irq_rise02", {irq_pending, irq_pending_n}, 6'b101101);
        irq_clr = 3'b001;
        cycle();
        irq_clr = 3'b000;
        chk("irq_clr0", {irq_pending, irq_pending_n}, 6'b100100);
        irq = 3'b000;
        // Reset in the middle of a stalled write with reads outstanding
        do_cmd(rv(32'h500));
        do_cmd(rv(32'h504));
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h600; cmd_wdata = 32'h77;
        cycle();
        cmd_valid = 1'b0;
        waitrequest = 1'b1;
        cycle();
        chk("mid_bus", {write, write_n}, 2'b11);
        #2 nreset = 1'b0;
        #1;
        chk("mr_ctl", {write, read, write_n, read_n}, 4'b0);
        chk("mr_be", {byteenable, byteenable_n}, 8'hFF);
        chk("mr_ready", {cmd_ready, cmd_ready_n}, 2'b11);
        chk("mr_err", {rsp_err, rsp_err_n, irq_pending}, 5'b0);
        sb.delete();
        pend.delete();
        cycle();
        nreset = 1'b1;
        waitrequest = 1'b0;
        readdatavalid = 1'b1;
        readdata = rd_val(32'h500);
        cycle();
        readdatavalid = 1'b0;
        chk("post_rst_discard", {rsp_valid, rsp_valid_n}, 2'b00);
        chk("post_rst_err", {rsp_err, rsp_err_n}, 2'b11);
        do_cmd('{1'b1, 32'h700, 32'h99, 0, 4'hF, 4'hF});
        cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
